imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Parametrised, pipelined RISC-V immediate generator for the decode stage of the FPGA RISC V core. Takes instruction bits [31:7] plus a format code from the control unit, builds the sign/zero-extended immediate for I, S, B, U and J formats (plus optional shift-amount format), and delivers it through a configurable-depth register pipeline with valid tagging, stall hold and a flush that blocks acceptance for one recovery cycle.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- DEPTH, 1: pipeline stages from input to output; legal 1..4.

- clk  in  1  processor main clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_inst/in_fmt carry an instruction this cycle.
- in_inst  in  25  instruction bits [31:7]; in_inst[k] = instruction bit k+7.
- in_fmt  in  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 reserved.
- stall  in  1  hold every stage; input not accepted.
- flush  in  1  kill all in-flight entries (codebase "nop").
- out_valid  out  1  out_imm/out_fmt valid.
- out_imm  out  XLEN  generated immediate.
- out_fmt  out  3  format code travelling with out_imm.
- out_illegal  out  1  format 7 (or 6 when SHAMT disabled) seen; out_imm = 0.

## Operation
- Stage 1 computes the immediate combinationally from in_inst and registers it; stages 2..DEPTH are plain delay registers (valid, imm, fmt, illegal).
- Formats (bit indices into in_inst; s = in_inst[24]):
  - I: imm[11:0] = in_inst[24:13]; bits XLEN-1..12 = s.
  - S: imm[11:5] = in_inst[24:18], imm[4:0] = in_inst[4:0]; upper = s.
  - B: imm[12] = s, imm[11] = in_inst[0], imm[10:5] = in_inst[23:18], imm[4:1] = in_inst[4:1], imm[0] = 0; upper = s.
  - U: imm[31:12] = in_inst[24:5], imm[11:0] = 0; for XLEN=64 bits 63:32 = s.
  - J: imm[20] = s, imm[19:12] = in_inst[12:5], imm[11] = in_inst[13], imm[10:1] = in_inst[23:14], imm[0] = 0; upper = s.
  - NONE: imm = 0, valid still propagates, illegal = 0.
- Stage written with valid = 0 carries imm = 0, fmt = 0, illegal = 0.
- Control FSM, two states:
  - RUN: stall=0, flush=0 -> accept input (valid = in_valid), advance. stall=1 -> all stages hold. flush=1 -> go HOLD.
  - HOLD: one cycle; input ignored, a bubble (valid 0) enters stage 1, rest of pipe advances unless stall. flush=1 in HOLD -> re-clear, stay HOLD. Otherwise -> RUN.
- Flush: all stage valid/imm/fmt/illegal cleared to 0 on the flush edge, stall notwithstanding (flush has priority over stall).

## Timing
- Reset: state RUN, every stage valid 0, imm 0, fmt 0, illegal 0; so out_valid=0, out_imm=0, out_fmt=0, out_illegal=0 from the first edge with rst=1. rst overrides flush and stall.
- Latency: input accepted at edge N appears on outputs after edge N+DEPTH-1 (DEPTH=1: visible right after the accepting edge), extended by one cycle per stalled cycle.
- Throughput: one instruction per cycle when stall=0 and state RUN.
- Instruction presented in the cycle flush asserts, or in the HOLD cycle, is dropped; first acceptable input is the cycle after HOLD (2 cycles after flush).
- Stall and flush both sampled on the same edge: flush wins, FSM enters HOLD.
- Reset mid-stream: all in-flight entries lost, no HOLD cycle follows reset.

## Configuration
- IMMGEN_SHAMT_EN defined: fmt 6 = SHAMT; imm = zero-extended shift amount, in_inst[17:13] for XLEN=32, in_inst[18:13] for XLEN=64; illegal only for fmt 7.
- Undefined: fmt 6 and 7 both illegal: out_imm = 0, out_illegal = 1 with out_valid = 1; no SHAMT logic synthesised.

## Test plan
- Reset/formats, XLEN=32 DEPTH=1: I with in_inst[24:13]=0xFFF -> out_imm 0xFFFFFFFF; S with in_inst[24:18]=0x01, [4:0]=0x04 -> 0x00000024; U with in_inst[24:5]=0x12345 -> 0x12345000; outputs all 0 while rst=1.
- B/J sign, XLEN=64: B with s=1, rest 0 -> 0xFFFFFFFFFFFFF000; J with in_inst[24:5]=0x7FE00 (bits 23:14 set only) -> 0x00000000000007FE; U with s=1 -> upper 32 bits all ones.
- DEPTH=3 streaming: 5 back-to-back I instructions imm 1..5 -> out_valid high for 5 consecutive cycles starting 2 edges after first accept, values 1..5 in order.
- Stall: DEPTH=2, stall high 3 cycles mid-stream -> outputs frozen 3 cycles, no entry lost or duplicated.
- Flush: flush at cycle N with stall also high -> out_valid 0 next cycle; inputs at N and N+1 dropped; input at N+2 emerges with correct imm; flush repeated in HOLD extends drop by one cycle.
- Macro: fmt 6, in_inst[17:13]=0x1F, XLEN=32 -> with IMMGEN_SHAMT_EN out_imm 0x1F, illegal 0; without it out_imm 0, illegal 1; fmt 7 -> illegal 1 in both builds.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator (I/S/B/U/J, optional SHAMT).
// Optional feature macro: IMMGEN_SHAMT_EN enables format 6 as a zero-extended shift amount;
// without it formats 6 and 7 are both flagged illegal.
// Stage 1 builds the immediate; stages 2..DEPTH are plain delay registers.
// A flush clears every stage and forces one HOLD cycle in which input is ignored.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [24:0]     in_inst,
    input  logic [2:0]      in_fmt,
    input  logic            stall,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam int unsigned FW  = 3;
    localparam int unsigned SHW = (XLEN == 64) ? 6 : 5;

    localparam logic [FW-1:0] FMT_NONE  = 3'd0;
    localparam logic [FW-1:0] FMT_I     = 3'd1;
    localparam logic [FW-1:0] FMT_S     = 3'd2;
    localparam logic [FW-1:0] FMT_B     = 3'd3;
    localparam logic [FW-1:0] FMT_U     = 3'd4;
    localparam logic [FW-1:0] FMT_J     = 3'd5;
    localparam logic [FW-1:0] FMT_SHAMT = 3'd6;

    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic [FW-1:0]   fmt;
        logic [XLEN-1:0] imm;
    } stage_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            accept_c;
    logic            advance_c;
    logic            clear_c;
    logic [XLEN-1:0] imm_c;
    logic            illegal_c;
    stage_t          entry_c;
    stage_t          stage_q [DEPTH];

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and pipeline control; flush beats stall, HOLD lasts one cycle
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        advance_c  = 1'b0;
        clear_c    = 1'b0;
        case (state)
            RUN: begin
                if (flush) begin
                    clear_c    = 1'b1;
                    state_next = HOLD;
                end else if (!stall) begin
                    advance_c = 1'b1;
                    accept_c  = 1'b1;
                end
            end
            HOLD: begin
                if (flush) begin
                    clear_c    = 1'b1;
                    state_next = HOLD;
                end else begin
                    advance_c  = !stall;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Immediate assembly from instruction bits [31:7]
    always_comb begin
        imm_c     = '0;
        illegal_c = 1'b0;
        case (in_fmt)
            FMT_NONE: imm_c = '0;
            FMT_I: begin
                imm_c       = {XLEN{in_inst[24]}};
                imm_c[11:0] = in_inst[24:13];
            end
            FMT_S: begin
                imm_c       = {XLEN{in_inst[24]}};
                imm_c[11:5] = in_inst[24:18];
                imm_c[4:0]  = in_inst[4:0];
            end
            FMT_B: begin
                imm_c       = {XLEN{in_inst[24]}};
                imm_c[11]   = in_inst[0];
                imm_c[10:5] = in_inst[23:18];
                imm_c[4:1]  = in_inst[4:1];
                imm_c[0]    = 1'b0;
            end
            FMT_U: begin
                imm_c        = {XLEN{in_inst[24]}};
                imm_c[31:12] = in_inst[24:5];
                imm_c[11:0]  = '0;
            end
            FMT_J: begin
                imm_c        = {XLEN{in_inst[24]}};
                imm_c[19:12] = in_inst[12:5];
                imm_c[11]    = in_inst[13];
                imm_c[10:1]  = in_inst[23:14];
                imm_c[0]     = 1'b0;
            end
`ifdef IMMGEN_SHAMT_EN
            FMT_SHAMT: imm_c[SHW-1:0] = in_inst[13 +: SHW];
`else
            FMT_SHAMT: illegal_c = 1'b1;
`endif
            default: illegal_c = 1'b1;
        endcase
    end

    // Stage-1 payload; anything not accepted becomes an all-zero bubble
    always_comb begin
        entry_c = '0;
        if (accept_c && in_valid) begin
            entry_c.valid   = 1'b1;
            entry_c.illegal = illegal_c;
            entry_c.fmt     = in_fmt;
            entry_c.imm     = illegal_c ? '0 : imm_c;
        end
    end

    // Pipeline registers: clear on reset/flush, hold on stall, else shift
    always_ff @(posedge clk) begin
        if (rst || clear_c) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else if (advance_c) begin
            stage_q[0] <= entry_c;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_valid   = stage_q[DEPTH-1].valid;
    assign out_imm     = stage_q[DEPTH-1].imm;
    assign out_fmt     = stage_q[DEPTH-1].fmt;
    assign out_illegal = stage_q[DEPTH-1].illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench driving two instances (XLEN=32/DEPTH=1 and
// XLEN=64/DEPTH=3) with shared stimulus; expectations from an ISA-level model.
module tb_imm_gen_pipe;

    localparam int unsigned D32 = 1;
    localparam int unsigned D64 = 3;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        longint      due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [24:0] in_inst;
    logic [2:0]  in_fmt;
    logic        stall;
    logic        flush;

    logic        v32, ill32, v64, ill64;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;

    int     total = 0;
    int     bad   = 0;
    bit     mon_en = 1'b0;
    bit     recovering = 1'b0;
    longint adv_cnt = 0;
    exp_t   q32[$];
    exp_t   q64[$];

    imm_gen_pipe #(.XLEN(32), .DEPTH(D32)) d32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_fmt(in_fmt),
        .stall(stall), .flush(flush), .out_valid(v32), .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(D64)) d64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_fmt(in_fmt),
        .stall(stall), .flush(flush), .out_valid(v64), .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64)
    );

    always #5 clk = ~clk;

    // ISA-level reference: rebuild the 32-bit instruction and decode it with signed arithmetic
    function automatic exp_t ref_model(input logic [24:0] ii, input logic [2:0] f, input int xlen);
        exp_t        e;
        logic [31:0] inst;
        int          w;
        longint      sx;
        longint      t;
        logic [63:0] r;
        logic        ill;
        inst = {ii, 7'b0};
        w    = inst;
        sx   = w;
        r    = 64'd0;
        ill  = 1'b0;
        case (f)
            3'd1: begin t = sx >>> 20; r = t; end
            3'd2: begin t = sx >>> 25; r = (t << 5) | 64'(inst[11:7]); end
            3'd3: begin
                t = sx >>> 31;
                r = (t << 12) | (64'(inst[7]) << 11) | (64'(inst[30:25]) << 5) | (64'(inst[11:8]) << 1);
            end
            3'd4: begin t = sx; r = t & ~64'hFFF; end
            3'd5: begin
                t = sx >>> 31;
                r = (t << 20) | (64'(inst[19:12]) << 12) | (64'(inst[20]) << 11) | (64'(inst[30:21]) << 1);
            end
`ifdef IMMGEN_SHAMT_EN
            3'd6: r = (xlen == 32) ? 64'(inst[24:20]) : 64'(inst[25:20]);
`else
            3'd6: ill = 1'b1;
`endif
            3'd7: ill = 1'b1;
            default: r = 64'd0;
        endcase
        if (xlen == 32) r[63:32] = 32'd0;
        if (ill) r = 64'd0;
        e.imm = r;
        e.fmt = f;
        e.ill = ill;
        e.due = 0;
        return e;
    endfunction

    // Stimulus side of the scoreboard: record what each edge does to the in-flight set
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            q32.delete();
            q64.delete();
            recovering = 1'b0;
            mon_en     = 1'b1;
        end else if (flush) begin
            q32.delete();
            q64.delete();
            recovering = 1'b1;
        end else if (stall) begin
            recovering = 1'b0;
        end else begin
            adv_cnt++;
            if (!recovering && in_valid) begin
                e     = ref_model(in_inst, in_fmt, 32);
                e.due = adv_cnt + longint'(D32) - 1;
                q32.push_back(e);
                e     = ref_model(in_inst, in_fmt, 64);
                e.due = adv_cnt + longint'(D64) - 1;
                q64.push_back(e);
            end
            recovering = 1'b0;
        end
    end

    task automatic compare(input string nm, input logic v, input logic [63:0] imm,
                           input logic [2:0] fmt, input logic ill, input bit ev, input exp_t e);
        logic        xv, xill;
        logic [63:0] ximm;
        logic [2:0]  xfmt;
        xv   = ev;
        ximm = ev ? e.imm : 64'd0;
        xfmt = ev ? e.fmt : 3'd0;
        xill = ev ? e.ill : 1'b0;
        total++;
        if ({v, ill, fmt, imm} !== {xv, xill, xfmt, ximm}) begin
            bad++;
            $display("FAIL %s t=%0t: got v=%b ill=%b fmt=%0d imm=%h, want v=%b ill=%b fmt=%0d imm=%h",
                     nm, $time, v, ill, fmt, imm, xv, xill, xfmt, ximm);
        end
    endtask

    // Monitor: the entry whose due count equals the advance count must be on the outputs
    always @(negedge clk) begin
        bit   ev;
        exp_t e;
        if (mon_en) begin
            while (q32.size() > 0 && q32[0].due < adv_cnt) void'(q32.pop_front());
            ev = (q32.size() > 0) && (q32[0].due == adv_cnt);
            if (ev) e = q32[0];
            else e = '{imm: 64'd0, fmt: 3'd0, ill: 1'b0, due: 0};
            compare("sb32", v32, 64'(imm32), fmt32, ill32, ev, e);

            while (q64.size() > 0 && q64[0].due < adv_cnt) void'(q64.pop_front());
            ev = (q64.size() > 0) && (q64[0].due == adv_cnt);
            if (ev) e = q64[0];
            else e = '{imm: 64'd0, fmt: 3'd0, ill: 1'b0, due: 0};
            compare("sb64", v64, imm64, fmt64, ill64, ev, e);
        end
    end

    task automatic cyc(input logic v, input logic [24:0] ii, input logic [2:0] f,
                       input logic st, input logic fl);
        in_valid = v;
        in_inst  = ii;
        in_fmt   = f;
        stall    = st;
        flush    = fl;
        @(negedge clk);
    endtask

    // Directed vector with literal expected values for both instances
    task automatic dvec(input string nm, input logic [24:0] ii, input logic [2:0] f,
                        input logic [31:0] x32, input logic xi32,
                        input logic [63:0] x64, input logic xi64);
        cyc(1'b1, ii, f, 1'b0, 1'b0);
        total++;
        if ({v32, ill32, imm32} !== {1'b1, xi32, x32}) begin
            bad++;
            $display("FAIL %s/32: got v=%b ill=%b imm=%h, want v=1 ill=%b imm=%h",
                     nm, v32, ill32, imm32, xi32, x32);
        end
        cyc(1'b0, 25'd0, 3'd0, 1'b0, 1'b0);
        cyc(1'b0, 25'd0, 3'd0, 1'b0, 1'b0);
        total++;
        if ({v64, ill64, imm64} !== {1'b1, xi64, x64}) begin
            bad++;
            $display("FAIL %s/64: got v=%b ill=%b imm=%h, want v=1 ill=%b imm=%h",
                     nm, v64, ill64, imm64, xi64, x64);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_fmt = '0; stall = 1'b0; flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        dvec("i_ones",  25'h1FFE000, 3'd1, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        dvec("s_small", 25'h0040004, 3'd2, 32'h00000024, 1'b0, 64'h0000000000000024, 1'b0);
        dvec("u_pos",   25'h02468A0, 3'd4, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0);
        dvec("b_sign",  25'h1000000, 3'd3, 32'hFFFFF000, 1'b0, 64'hFFFFFFFFFFFFF000, 1'b0);
        dvec("j_mid",   25'h0FFC000, 3'd5, 32'h000007FE, 1'b0, 64'h00000000000007FE, 1'b0);
        dvec("u_neg",   25'h1000000, 3'd4, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000, 1'b0);
`ifdef IMMGEN_SHAMT_EN
        dvec("shamt",   25'h003E000, 3'd6, 32'h0000001F, 1'b0, 64'h000000000000001F, 1'b0);
`else
        dvec("shamt",   25'h003E000, 3'd6, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1);
`endif
        dvec("fmt7",    25'h1FFFFFF, 3'd7, 32'h00000000, 1'b1, 64'h0000000000000000, 1'b1);

        // Back-to-back stream with a 3-cycle stall in the middle
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, {12'(i), 13'd0}, 3'd1, 1'b0, 1'b0);
            if (i == 3) begin
                for (int k = 0; k < 3; k++) cyc(1'b1, 25'h1555555, 3'd2, 1'b1, 1'b0);
            end
        end

        // Flush with stall, repeated flush in HOLD, then recovery
        cyc(1'b1, 25'h0123000, 3'd1, 1'b1, 1'b1);
        cyc(1'b1, 25'h0456000, 3'd1, 1'b0, 1'b1);
        cyc(1'b1, 25'h0789000, 3'd1, 1'b0, 1'b0);
        cyc(1'b1, 25'h0ABC000, 3'd1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 25'd0, 3'd0, 1'b0, 1'b0);

        // Randomized traffic with occasional stall, flush and reset
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            cyc(($urandom_range(0, 9) < 8), 25'($urandom), 3'($urandom_range(0, 7)),
                ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 5));
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) cyc(1'b0, 25'd0, 3'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
